instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 6: width of the instruction-memory address bus.
REQ-002 Parameter ADDR_STEP, default 4: address increment per written word; addresses are byte-style and index memory directly.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a load session; sampled only in IDLE or DONE.
REQ-006 base_addr  input  ADDR_W  first write address, latched on accepted start.
REQ-007 num_words  input  5  number of 32-bit words to load, latched on accepted start.
REQ-008 byte_in  input  8  serial program byte.
REQ-009 byte_valid  input  1  byte_in holds a valid byte.
REQ-010 byte_ready  output  1  loader can accept a byte this cycle.
REQ-011 mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-012 mem_wa  output  ADDR_W  instruction-memory write address.
REQ-013 mem_wd  output  32  instruction-memory write data.
REQ-014 cpu_hold  output  1  keeps the processor stalled or in reset while a load is in progress.
REQ-015 busy  output  1  a session is active (RECV or WRITE).
REQ-016 done  output  1  last session completed; held until the next accepted start or reset.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, RECV, WRITE and DONE.
REQ-018 IDLE/DONE + start=1 SHALL latch base_addr into the address register, latch num_words, clear the word and byte counters, clear done, and enter RECV; if num_words=0, it SHALL enter DONE directly instead.
REQ-019 start SHALL be ignored in RECV and WRITE.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte SHALL be accepted only on a cycle where byte_valid and byte_ready are both 1.
REQ-021 Bytes SHALL be assembled big-endian: 1st accepted byte to bits 31:24, 2nd to 23:16, 3rd to 15:8, 4th to 7:0.
REQ-022 On acceptance of the 4th byte, the FSM SHALL enter WRITE on the next edge; byte_valid gaps SHALL stall assembly without losing bytes.
REQ-023 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_wa equal to the current address and mem_wd equal to the assembled word.
REQ-024 On leaving WRITE, the address SHALL advance by ADDR_STEP modulo 2^ADDR_W (wrap-around, no error), and the word counter SHALL increment.
REQ-025 On leaving WRITE, the FSM SHALL enter DONE if the incremented word count equals num_words, otherwise RECV.
REQ-026 Minimum throughput SHALL be 5 cycles per word (4 accept cycles plus 1 write cycle).
REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_wa and mem_wd SHALL hold their values when mem_we=0.
REQ-028 cpu_hold and busy SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-029 In DONE, start=1 SHALL begin a new session exactly as from IDLE.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, regardless of clk, including mid-word or mid-session; the partial word SHALL be discarded.
REQ-031 Reset values SHALL be: byte_ready=0, mem_we=0, mem_wa=0, mem_wd=0, cpu_hold=0, busy=0, done=0, and all counters 0.

Verification
REQ-032 The bench SHALL cover: start, base_addr=0, num_words=2; bytes 20 02 00 05 20 03 00 0C -> writes 0x20020005@0 then 0x2003000C@4, done=1, cpu_hold=0.
REQ-033 The bench SHALL cover: byte_valid toggled every other cycle during one word -> same written word, with mem_we asserted once, 8 or more cycles after start.
REQ-034 The bench SHALL cover: base_addr=60, num_words=2 -> writes at address 60 then 0 (wrap-around).
REQ-035 The bench SHALL cover: num_words=0 -> DONE one cycle after start, with no mem_we pulse and byte_ready never asserted.
REQ-036 The bench SHALL cover: reset asserted after 2 bytes of a word -> all outputs at reset values asynchronously; a subsequent session writes only new data.
REQ-037 The bench SHALL cover: start pulsed during RECV -> ignored, with the address and word count unchanged.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Serial byte loader for instruction memory: assembles big-endian 32-bit words
// from a byte stream and writes them to consecutive addresses while the CPU is held.
module instr_mem_loader #(
    parameter int ADDR_W    = 6,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] addrReg;
    logic [4:0]        numWordsReg;
    logic [4:0]        wordCnt;
    logic [1:0]        byteCnt;
    logic [23:0]       partialWord;
    logic              byteAccept;
    logic              startAccept;
    logic              lastWord;

    assign byteAccept  = byte_valid && (state == RECV);
    assign startAccept = start && ((state == IDLE) || (state == DONE));
    assign lastWord    = (wordCnt + 5'd1) == numWordsReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (startAccept) begin
                    nextState = (num_words == 5'd0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byteAccept && (byteCnt == 2'd3)) begin
                    nextState = WRITE;
                end
            end
            WRITE:   nextState = lastWord ? DONE : RECV;
            default: nextState = IDLE;
        endcase
    end

    // The write port registers are loaded with the finished word on its last byte,
    // so they are valid throughout WRITE and hold afterwards while addrReg moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrReg     <= '0;
            numWordsReg <= '0;
            wordCnt     <= '0;
            byteCnt     <= '0;
            partialWord <= '0;
            mem_wa      <= '0;
            mem_wd      <= '0;
        end else begin
            if (startAccept) begin
                addrReg     <= base_addr;
                numWordsReg <= num_words;
                wordCnt     <= '0;
                byteCnt     <= '0;
            end
            if (byteAccept) begin
                byteCnt <= byteCnt + 2'd1;
                if (byteCnt == 2'd3) begin
                    mem_wa <= addrReg;
                    mem_wd <= {partialWord, byte_in};
                end else begin
                    partialWord <= {partialWord[15:0], byte_in};
                end
            end
            if (state == WRITE) begin
                addrReg <= addrReg + STEP;
                wordCnt <= wordCnt + 5'd1;
            end
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RECV: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_we   = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
